// File: rtl/huffman_encode_core.sv
// Huffman encoder core: table lookup of each symbol, MSB-first packing of the
// variable-length codes into OUT_W-bit words, valid/ready word handoff.
module huffman_encode_core #(
   parameter int SYM_W        = 8,
   parameter int MAX_CODE_LEN = 16,
   parameter int OUT_W        = 32
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic                    tbl_we,
   input  logic [SYM_W-1:0]        tbl_addr,
   input  logic [MAX_CODE_LEN-1:0] tbl_code,
   input  logic [4:0]              tbl_len,
   input  logic                    sym_valid,
   output logic                    sym_ready,
   input  logic [SYM_W-1:0]        sym_data,
   input  logic                    sym_last,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic [OUT_W-1:0]        word_data,
   output logic [5:0]              word_bits,
   output logic                    word_last,
   output logic                    busy,
   output logic                    err_zero_len,
   input  logic                    clr_err
);

   localparam int ACC_W  = OUT_W + MAX_CODE_LEN;
   localparam int ENT_W  = MAX_CODE_LEN + 5;
   localparam int DEPTH  = 2 ** SYM_W;
   localparam int FILL_W = $clog2(ACC_W + 1);
   localparam logic [ACC_W-1:0] ONE_ACC = {{(ACC_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOOK = 2'd1,
      ST_PACK = 2'd2,
      ST_EMIT = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [ACC_W-1:0]    acc_r, acc_nxt_s;
   logic [FILL_W-1:0]   fill_r, fill_nxt_s;
   logic                last_r, last_nxt_s;
   logic                err_r, err_nxt_s;
   logic [SYM_W-1:0]    sym_r, sym_nxt_s;
   logic [ENT_W-1:0]    tbl_mem_r [DEPTH];
   logic [ENT_W-1:0]    rd_entry_r;
   logic [4:0]          len_eff_s;
   logic [FILL_W-1:0]   drain_s;

   logic                sym_ready_r, word_valid_r, word_last_r, busy_r;
   logic [OUT_W-1:0]    word_data_r;
   logic [5:0]          word_bits_r;

   // Bits handed out by one word: the fill, capped at the word width.
   function automatic logic [FILL_W-1:0] drain_bits(input logic [FILL_W-1:0] fill);
      if (fill > FILL_W'(OUT_W)) begin
         return FILL_W'(OUT_W);
      end else begin
         return fill;
      end
   endfunction

   // Code masked to its length and positioned directly below the current fill.
   function automatic logic [ACC_W-1:0] place_code(input logic [MAX_CODE_LEN-1:0] code,
                                                  input logic [4:0]              len,
                                                  input logic [FILL_W-1:0]       fill);
      logic [ACC_W-1:0] ext;
      logic [ACC_W-1:0] mask;
      int unsigned      shamt;
      ext   = {{OUT_W{1'b0}}, code};
      mask  = (ONE_ACC << len) - ONE_ACC;
      shamt = ACC_W - int'(fill) - int'(len);
      return (ext & mask) << shamt;
   endfunction

   // Code table RAM; contents survive reset, read returns pre-write data.
   always_ff @(posedge s00_axi_aclk) begin
      if (tbl_we) begin
         tbl_mem_r[tbl_addr] <= {tbl_len, tbl_code};
      end
      rd_entry_r <= tbl_mem_r[sym_r];
   end

   // Out-of-range lengths are clamped so the append never overflows the accumulator.
   assign len_eff_s = (rd_entry_r[ENT_W-1 -: 5] > 5'(MAX_CODE_LEN)) ? 5'(MAX_CODE_LEN)
                                                                     : rd_entry_r[ENT_W-1 -: 5];
   assign drain_s   = drain_bits(fill_r);

   // Next-state, accumulator and error-flag logic.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      fill_nxt_s  = fill_r;
      last_nxt_s  = last_r;
      sym_nxt_s   = sym_r;
      if (clr_err) begin
         err_nxt_s = 1'b0;
      end else begin
         err_nxt_s = err_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (sym_valid && sym_ready_r) begin
               sym_nxt_s   = sym_data;
               last_nxt_s  = sym_last;
               state_nxt_s = ST_LOOK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOOK: begin
            state_nxt_s = ST_PACK;
         end
         ST_PACK: begin
            if (len_eff_s == 5'd0) begin
               err_nxt_s = 1'b1;
            end else begin
               acc_nxt_s  = acc_r | place_code(rd_entry_r[MAX_CODE_LEN-1:0], len_eff_s, fill_r);
               fill_nxt_s = fill_r + FILL_W'(len_eff_s);
            end
            if (fill_nxt_s >= FILL_W'(OUT_W)) begin
               state_nxt_s = ST_EMIT;
            end else if (last_r) begin
               state_nxt_s = ST_EMIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (word_ready) begin
               acc_nxt_s  = acc_r << OUT_W;
               fill_nxt_s = fill_r - drain_s;
               if (last_r && (fill_nxt_s != {FILL_W{1'b0}})) begin
                  state_nxt_s = ST_EMIT;
               end else begin
                  state_nxt_s = ST_IDLE;
                  last_nxt_s  = 1'b0;
               end
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs track the upcoming state.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_r      <= ST_IDLE;
         acc_r        <= {ACC_W{1'b0}};
         fill_r       <= {FILL_W{1'b0}};
         last_r       <= 1'b0;
         err_r        <= 1'b0;
         sym_r        <= {SYM_W{1'b0}};
         sym_ready_r  <= 1'b1;
         word_valid_r <= 1'b0;
         word_data_r  <= {OUT_W{1'b0}};
         word_bits_r  <= 6'd0;
         word_last_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         acc_r        <= acc_nxt_s;
         fill_r       <= fill_nxt_s;
         last_r       <= last_nxt_s;
         err_r        <= err_nxt_s;
         sym_r        <= sym_nxt_s;
         sym_ready_r  <= (state_nxt_s == ST_IDLE);
         busy_r       <= (state_nxt_s != ST_IDLE);
         word_valid_r <= (state_nxt_s == ST_EMIT);
         word_data_r  <= (state_nxt_s == ST_EMIT) ? acc_nxt_s[ACC_W-1 -: OUT_W] : {OUT_W{1'b0}};
         word_bits_r  <= (state_nxt_s == ST_EMIT) ? 6'(drain_bits(fill_nxt_s)) : 6'd0;
         word_last_r  <= (state_nxt_s == ST_EMIT) && last_nxt_s && (fill_nxt_s <= FILL_W'(OUT_W));
      end
   end

   assign sym_ready    = sym_ready_r;
   assign word_valid   = word_valid_r;
   assign word_data    = word_data_r;
   assign word_bits    = word_bits_r;
   assign word_last    = word_last_r;
   assign busy         = busy_r;
   assign err_zero_len = err_r;

endmodule

// File: tb/tb_huffman_encode_core.sv
// Directed bench for huffman_encode_core: hand-computed packed words per scenario.
module tb_huffman_encode_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tbl_we;
   logic [7:0]  tbl_addr;
   logic [15:0] tbl_code;
   logic [4:0]  tbl_len;
   logic        sym_valid;
   logic        sym_ready;
   logic [7:0]  sym_data;
   logic        sym_last;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] word_data;
   logic [5:0]  word_bits;
   logic        word_last;
   logic        busy;
   logic        err_zero_len;
   logic        clr_err;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   huffman_encode_core dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .tbl_we         (tbl_we),
      .tbl_addr       (tbl_addr),
      .tbl_code       (tbl_code),
      .tbl_len        (tbl_len),
      .sym_valid      (sym_valid),
      .sym_ready      (sym_ready),
      .sym_data       (sym_data),
      .sym_last       (sym_last),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .word_data      (word_data),
      .word_bits      (word_bits),
      .word_last      (word_last),
      .busy           (busy),
      .err_zero_len   (err_zero_len),
      .clr_err        (clr_err)
   );

   task automatic write_entry(input logic [7:0] a, input logic [15:0] c, input logic [4:0] l);
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   task automatic send_sym(input logic [7:0] s, input logic l);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (sym_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL sym_timeout: sym_ready=%0b required 1 within 40 cycles", sym_ready);
      end else begin
         sym_valid = 1'b1; sym_data = s; sym_last = l;
         @(posedge clk);
         #1;
         sym_valid = 1'b0; sym_last = 1'b0;
      end
   endtask

   task automatic wait_word();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (word_valid) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL word_timeout: word_valid=%0b required 1 within 40 cycles", word_valid);
      end
   endtask

   task automatic accept_word();
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      word_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tbl_we = 1'b0; tbl_addr = 8'h00; tbl_code = 16'h0000; tbl_len = 5'd0;
      sym_valid = 1'b0; sym_data = 8'h00; sym_last = 1'b0;
      word_ready = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sym_ready, word_valid, word_last, busy, err_zero_len} !== 5'b10000) begin
         n_fails++;
         $display("FAIL reset_flags: rdy/val/last/busy/err=%b required 10000",
                  {sym_ready, word_valid, word_last, busy, err_zero_len});
      end
      n_checks++;
      if ({word_data, word_bits} !== 38'd0) begin
         n_fails++;
         $display("FAIL reset_word: data=%h bits=%0d required 0/0", word_data, word_bits);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      send_sym(8'h41, 1'b0);
      send_sym(8'h42, 1'b0);
      send_sym(8'h43, 1'b0);
      send_sym(8'h41, 1'b1);
      // Accept edge ends cycle 0; the word must appear in cycle 3, not earlier.
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (word_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL basic_early: word_valid=%0b in cycle 2 required 0", word_valid);
      end
      @(negedge clk);
      n_checks++;
      if (word_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL basic_latency: word_valid=%0b in cycle 3 required 1", word_valid);
      end
      n_checks++;
      if (word_data !== 32'h5800_0000 || word_bits !== 6'd6 || word_last !== 1'b1) begin
         n_fails++;
         $display("FAIL basic_word: data=%h bits=%0d last=%0b required 58000000/6/1",
                  word_data, word_bits, word_last);
      end
      n_checks++;
      if (sym_ready !== 1'b0 || busy !== 1'b1) begin
         n_fails++;
         $display("FAIL basic_emit_flags: sym_ready=%0b busy=%0b required 0/1", sym_ready, busy);
      end
      accept_word();
      repeat (3) @(negedge clk);
      n_checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL basic_idle: word_valid=%0b busy=%0b required 0/0", word_valid, busy);
      end
   endtask

   task automatic test_word_boundary();
      for (int i = 0; i < 8; i++) begin
         send_sym(8'h55, (i == 7) ? 1'b1 : 1'b0);
      end
      wait_word();
      n_checks++;
      if (word_data !== 32'hAAAA_AAAA || word_bits !== 6'd32 || word_last !== 1'b1) begin
         n_fails++;
         $display("FAIL boundary_word: data=%h bits=%0d last=%0b required aaaaaaaa/32/1",
                  word_data, word_bits, word_last);
      end
      accept_word();
      repeat (4) @(negedge clk);
      n_checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL boundary_no_empty: word_valid=%0b busy=%0b required 0/0", word_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d0;
      logic [5:0]  b0;
      bit          stable;
      send_sym(8'hFF, 1'b0);
      send_sym(8'hFF, 1'b0);
      wait_word();
      n_checks++;
      if (word_data !== 32'hFFFF_FFFF || word_bits !== 6'd32 || word_last !== 1'b0) begin
         n_fails++;
         $display("FAIL multi_word0: data=%h bits=%0d last=%0b required ffffffff/32/0",
                  word_data, word_bits, word_last);
      end
      d0 = word_data;
      b0 = word_bits;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!word_valid || word_data !== d0 || word_bits !== b0 || sym_ready !== 1'b0) begin
            stable = 1'b0;
         end
      end
      n_checks++;
      if (!stable) begin
         n_fails++;
         $display("FAIL stall_stable: valid=%0b data=%h bits=%0d sym_ready=%0b required 1/%h/%0d/0",
                  word_valid, word_data, word_bits, sym_ready, d0, b0);
      end
      accept_word();
      send_sym(8'hFF, 1'b1);
      wait_word();
      n_checks++;
      if (word_data !== 32'hFFFF_0000 || word_bits !== 6'd16 || word_last !== 1'b1) begin
         n_fails++;
         $display("FAIL multi_word1: data=%h bits=%0d last=%0b required ffff0000/16/1",
                  word_data, word_bits, word_last);
      end
      accept_word();
      repeat (3) @(negedge clk);
      n_checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL multi_idle: word_valid=%0b busy=%0b required 0/0", word_valid, busy);
      end
   endtask

   task automatic test_zero_len();
      send_sym(8'h00, 1'b1);
      wait_word();
      n_checks++;
      if (word_data !== 32'h0 || word_bits !== 6'd0 || word_last !== 1'b1) begin
         n_fails++;
         $display("FAIL zero_word: data=%h bits=%0d last=%0b required 00000000/0/1",
                  word_data, word_bits, word_last);
      end
      n_checks++;
      if (err_zero_len !== 1'b1) begin
         n_fails++;
         $display("FAIL zero_err_set: err_zero_len=%0b required 1", err_zero_len);
      end
      accept_word();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_checks++;
      if (err_zero_len !== 1'b0) begin
         n_fails++;
         $display("FAIL zero_err_clr: err_zero_len=%0b required 0", err_zero_len);
      end
   endtask

   task automatic test_reset_mid();
      send_sym(8'h41, 1'b0);
      send_sym(8'h42, 1'b0);
      send_sym(8'h43, 1'b0);
      send_sym(8'h41, 1'b1);
      wait_word();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (word_valid !== 1'b0 || busy !== 1'b0 || sym_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL midreset_flags: valid=%0b busy=%0b sym_ready=%0b required 0/0/1",
                  word_valid, busy, sym_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // B then A: 10 followed by 0 -> 100 in a clean accumulator.
      send_sym(8'h42, 1'b0);
      send_sym(8'h41, 1'b1);
      wait_word();
      n_checks++;
      if (word_data !== 32'h8000_0000 || word_bits !== 6'd3 || word_last !== 1'b1) begin
         n_fails++;
         $display("FAIL midreset_fresh: data=%h bits=%0d last=%0b required 80000000/3/1",
                  word_data, word_bits, word_last);
      end
      accept_word();
   endtask

   initial begin
      test_reset();
      write_entry(8'h41, 16'h0000, 5'd1);
      write_entry(8'h42, 16'h0002, 5'd2);
      write_entry(8'h43, 16'h0003, 5'd2);
      write_entry(8'h55, 16'h000A, 5'd4);
      write_entry(8'hFF, 16'hFFFF, 5'd16);
      write_entry(8'h00, 16'h0000, 5'd0);
      test_basic();
      test_word_boundary();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
